// File: rtl/axi4_write_dma_if.sv
// AXI4 write channels (AW/W/B) plus the AXI-Stream input of the write DMA.
//   master : the DMA side. It drives AW/W, bready and s_axis_tready.
//   slave  : the memory/stream side. It drives the readies, B and the stream.
interface axi4_write_dma_if #(
  parameter int AXI_ADDR_WIDTH  = 64,
  parameter int AXI_DATA_WIDTH  = 128,
  parameter int AXI_ID_WIDTH    = 1,
  parameter int AXIS_DATA_WIDTH = 32
);
  // AW channel
  logic [AXI_ID_WIDTH-1:0]     m_axi_awid;
  logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr;
  logic [7:0]                  m_axi_awlen;
  logic [2:0]                  m_axi_awsize;
  logic [1:0]                  m_axi_awburst;
  logic                        m_axi_awlock;
  logic [3:0]                  m_axi_awcache;
  logic [2:0]                  m_axi_awprot;
  logic [3:0]                  m_axi_awqos;
  logic                        m_axi_awvalid;
  logic                        m_axi_awready;
  // W channel
  logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb;
  logic                        m_axi_wlast;
  logic                        m_axi_wvalid;
  logic                        m_axi_wready;
  // B channel
  logic [AXI_ID_WIDTH-1:0]     m_axi_bid;
  logic [1:0]                  m_axi_bresp;
  logic                        m_axi_bvalid;
  logic                        m_axi_bready;
  // input stream
  logic [AXIS_DATA_WIDTH-1:0]  s_axis_tdata;
  logic                        s_axis_tvalid;
  logic                        s_axis_tlast;
  logic                        s_axis_tready;

  modport master (
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
           m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready
  );

  modport slave (
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
           m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bid, m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready
  );
endinterface

// File: rtl/axi4_write_dma.sv
// AXI-Stream to AXI4 write DMA.
// It packs narrow stream words into full AXI beats, with word 0 in the LSBs.
// It writes them as INCR bursts that never cross 4 KB, with a single burst
// outstanding at a time.
// Ports:
//   aclk, areset      : clock and asynchronous active-high reset
//   start_addr        : destination byte address, beat aligned
//   transfer_length   : length in bytes
//   start             : level start. done holds until start drops.
//   done, error       : completion and sticky error flag
//   bus (master)      : AW/W/B write channels and s_axis input stream
module axi4_write_dma #(
  parameter int AXI_ADDR_WIDTH  = 64,
  parameter int AXI_DATA_WIDTH  = 128,
  parameter int AXI_ID_WIDTH    = 1,
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int MAX_BURST_LEN   = 256
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [AXI_ADDR_WIDTH-1:0] start_addr,
  input  logic [31:0]               transfer_length,
  input  logic                      start,
  output logic                      done,
  output logic                      error,
  axi4_write_dma_if.master          bus
);
  localparam int BPB    = AXI_DATA_WIDTH / 8;
  localparam int WPB    = AXI_DATA_WIDTH / AXIS_DATA_WIDTH;
  localparam int OFFB   = $clog2(BPB);
  localparam int WOFF   = $clog2(AXIS_DATA_WIDTH / 8);
  localparam int WIDX_W = (WPB > 1) ? $clog2(WPB) : 1;

  typedef enum logic [2:0] {IDLE, CHECK, ISSUE_AW, PACK, SEND_W, WAIT_B, DONE} state_t;

  state_t                    state_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [31:0]               len_q;
  logic [31:0]               beats_left_q;
  logic [31:0]               words_left_q;
  logic [8:0]                blen_q;
  logic [8:0]                wbeat_q;
  logic [WIDX_W-1:0]         widx_q;
  logic                      done_q, error_q;
  logic                      awvalid_q;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic [7:0]                awlen_q;
  logic [2:0]                awsize_q;
  logic [1:0]                awburst_q;
  logic [3:0]                awcache_q;
  logic                      wvalid_q, wlast_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic [BPB-1:0]            wstrb_q;
  logic                      bready_q, tready_q;

  // This is the length of the next burst. It is capped by the beats that
  // remain, by the burst limit, and by the distance to the next 4 KB page.
  logic [31:0] to4k_d, blen_d;
  always_comb begin
    to4k_d = 32'((13'h1000 - {1'b0, addr_q[11:0]}) >> OFFB);
    blen_d = beats_left_q;
    if (blen_d > 32'(MAX_BURST_LEN)) blen_d = 32'(MAX_BURST_LEN);
    if (blen_d > to4k_d)             blen_d = to4k_d;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      beats_left_q <= '0;
      words_left_q <= '0;
      blen_q       <= '0;
      wbeat_q      <= '0;
      widx_q       <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      awvalid_q    <= 1'b0;
      awaddr_q     <= '0;
      awlen_q      <= '0;
      awsize_q     <= '0;
      awburst_q    <= '0;
      awcache_q    <= '0;
      wvalid_q     <= 1'b0;
      wlast_q      <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      bready_q     <= 1'b0;
      tready_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q  <= 1'b0;
          error_q <= 1'b0;
          if (start) begin
            addr_q       <= start_addr;
            len_q        <= transfer_length;
            beats_left_q <= transfer_length >> OFFB;
            words_left_q <= transfer_length >> WOFF;
            state_q      <= CHECK;
          end
        end
        CHECK: begin
          if (len_q == 32'd0 || (len_q & 32'(BPB - 1)) != 32'd0 ||
              (addr_q & AXI_ADDR_WIDTH'(BPB - 1)) != '0) begin
            error_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= ISSUE_AW;
          end
        end
        ISSUE_AW: begin
          // The first cycle loads the payload and raises awvalid. The
          // payload then holds until awready.
          if (!awvalid_q) begin
            awvalid_q <= 1'b1;
            awaddr_q  <= addr_q;
            awlen_q   <= 8'(blen_d - 32'd1);
            awsize_q  <= 3'(OFFB);
            awburst_q <= 2'b01;
            awcache_q <= 4'b0011;
            blen_q    <= 9'(blen_d);
          end else if (bus.m_axi_awready) begin
            awvalid_q <= 1'b0;
            wbeat_q   <= '0;
            widx_q    <= '0;
            tready_q  <= 1'b1;
            state_q   <= PACK;
          end
        end
        PACK: begin
          if (tready_q && bus.s_axis_tvalid) begin
            wdata_q[widx_q*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] <= bus.s_axis_tdata;
            words_left_q <= words_left_q - 32'd1;
            // tlast must mark exactly the final word of the transfer. On a
            // mismatch the word is still consumed and the transfer continues.
            if (bus.s_axis_tlast != (words_left_q == 32'd1)) error_q <= 1'b1;
            if (widx_q == WIDX_W'(WPB - 1)) begin
              widx_q   <= '0;
              tready_q <= 1'b0;
              wvalid_q <= 1'b1;
              wstrb_q  <= '1;
              wlast_q  <= (wbeat_q == blen_q - 9'd1);
              state_q  <= SEND_W;
            end else begin
              widx_q <= widx_q + 1'b1;
            end
          end
        end
        SEND_W: begin
          if (bus.m_axi_wready) begin
            wvalid_q <= 1'b0;
            wlast_q  <= 1'b0;
            wbeat_q  <= wbeat_q + 9'd1;
            if (wlast_q) begin
              bready_q <= 1'b1;
              state_q  <= WAIT_B;
            end else begin
              tready_q <= 1'b1;
              state_q  <= PACK;
            end
          end
        end
        WAIT_B: begin
          if (bus.m_axi_bvalid) begin
            bready_q <= 1'b0;
            if (bus.m_axi_bresp != 2'b00) begin
              // A failed burst abandons the rest of the transfer.
              error_q <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              addr_q       <= addr_q + (AXI_ADDR_WIDTH'(blen_q) << OFFB);
              beats_left_q <= beats_left_q - 32'(blen_q);
              if (beats_left_q == 32'(blen_q)) begin
                done_q  <= 1'b1;
                state_q <= DONE;
              end else begin
                state_q <= ISSUE_AW;
              end
            end
          end
        end
        DONE: begin
          if (!start) begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The write response ID carries no information with one burst in flight.
  logic unused_bid;
  assign unused_bid = ^bus.m_axi_bid;

  assign done              = done_q;
  assign error             = error_q;
  assign bus.m_axi_awid    = '0;
  assign bus.m_axi_awaddr  = awaddr_q;
  assign bus.m_axi_awlen   = awlen_q;
  assign bus.m_axi_awsize  = awsize_q;
  assign bus.m_axi_awburst = awburst_q;
  assign bus.m_axi_awlock  = 1'b0;
  assign bus.m_axi_awcache = awcache_q;
  assign bus.m_axi_awprot  = 3'b000;
  assign bus.m_axi_awqos   = 4'b0000;
  assign bus.m_axi_awvalid = awvalid_q;
  assign bus.m_axi_wdata   = wdata_q;
  assign bus.m_axi_wstrb   = wstrb_q;
  assign bus.m_axi_wlast   = wlast_q;
  assign bus.m_axi_wvalid  = wvalid_q;
  assign bus.m_axi_bready  = bready_q;
  assign bus.s_axis_tready = tready_q;
endmodule

// File: tb/tb_axi4_write_dma.sv
// Scoreboard bench for axi4_write_dma.
// The directed tests push the expected AW and W transactions into queues. A
// negedge monitor pops them and compares on every handshake. It also checks
// that valid payloads hold steady while they are stalled.
module tb_axi4_write_dma;
  localparam int AW = 64, DW = 128, IW = 1, SW = 32;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [AW-1:0] start_addr;
  logic [31:0]   transfer_length;
  logic          start;
  logic          done, error;

  always #5 aclk = ~aclk;

  axi4_write_dma_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
                      .AXI_ID_WIDTH(IW), .AXIS_DATA_WIDTH(SW)) bus ();

  axi4_write_dma #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
                   .AXIS_DATA_WIDTH(SW), .MAX_BURST_LEN(256)) dut (
    .aclk(aclk), .areset(areset), .start_addr(start_addr),
    .transfer_length(transfer_length), .start(start), .done(done),
    .error(error), .bus(bus)
  );

  typedef struct { logic [63:0] addr; logic [7:0] len; } aw_t;
  typedef struct { logic [127:0] data; logic last; } w_t;

  aw_t        exp_aw[$];
  w_t         exp_w[$];
  logic [1:0] bresp_plan[$];
  int         checks = 0, failures = 0;
  int         b_pend = 0;
  bit         bp_en = 1'b0;
  int         word_ctr, stream_base;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s", nm);
  endtask

  // Queue one burst. Each expected beat packs four consecutive stream words,
  // with the lowest word in the LSBs.
  task automatic push_burst(input logic [63:0] a, input int beats);
    logic [127:0] d;
    exp_aw.push_back('{a, 8'(beats - 1)});
    for (int k = 0; k < beats; k++) begin
      for (int j = 0; j < 4; j++) d[j*32 +: 32] = 32'(word_ctr + j);
      exp_w.push_back('{d, (k == beats - 1)});
      word_ctr += 4;
    end
  endtask

  // monitor
  aw_t          ea;
  w_t           ew;
  logic         pv_aw = 1'b0, pv_w = 1'b0;
  logic [63:0]  p_awaddr;
  logic [7:0]   p_awlen;
  logic [127:0] p_wdata;
  logic         p_wlast;

  always @(negedge aclk) begin
    if (!areset) begin
      if (pv_aw)
        chk("aw_stable", 128'({bus.m_axi_awvalid, bus.m_axi_awaddr, bus.m_axi_awlen}),
            128'({1'b1, p_awaddr, p_awlen}));
      if (pv_w) begin
        chk("w_stable_ctl", 128'({bus.m_axi_wvalid, bus.m_axi_wlast}), 128'({1'b1, p_wlast}));
        chk("w_stable_data", bus.m_axi_wdata, p_wdata);
      end
      if (bus.m_axi_awvalid && bus.m_axi_awready) begin
        if (exp_aw.size() == 0) fail_now("aw_unexpected");
        else begin
          ea = exp_aw.pop_front();
          chk("awaddr", 128'(bus.m_axi_awaddr), 128'(ea.addr));
          chk("awlen", 128'(bus.m_axi_awlen), 128'(ea.len));
          chk("aw_attr", 128'({bus.m_axi_awsize, bus.m_axi_awburst, bus.m_axi_awcache,
                               bus.m_axi_awlock, bus.m_axi_awprot, bus.m_axi_awqos, bus.m_axi_awid}),
              128'({3'd4, 2'b01, 4'b0011, 1'b0, 3'b000, 4'b0000, 1'b0}));
        end
      end
      if (bus.m_axi_wvalid && bus.m_axi_wready) begin
        if (exp_w.size() == 0) fail_now("w_unexpected");
        else begin
          ew = exp_w.pop_front();
          chk("wdata", bus.m_axi_wdata, ew.data);
          chk("wlast_strb", 128'({bus.m_axi_wlast, bus.m_axi_wstrb}), 128'({ew.last, 16'hFFFF}));
        end
        if (bus.m_axi_wlast) b_pend++;
      end
      pv_aw    = bus.m_axi_awvalid && !bus.m_axi_awready;
      p_awaddr = bus.m_axi_awaddr;
      p_awlen  = bus.m_axi_awlen;
      pv_w     = bus.m_axi_wvalid && !bus.m_axi_wready;
      p_wdata  = bus.m_axi_wdata;
      p_wlast  = bus.m_axi_wlast;
    end
  end

  // AW/W ready generator
  initial begin
    bus.m_axi_awready = 1'b0;
    bus.m_axi_wready  = 1'b0;
    forever begin
      @(posedge aclk); #1;
      bus.m_axi_awready = bp_en ? ($urandom_range(0, 2) == 0) : 1'b1;
      bus.m_axi_wready  = bp_en ? ($urandom_range(0, 2) == 0) : 1'b1;
    end
  end

  // B responder: this returns one response per completed burst.
  initial begin
    bus.m_axi_bvalid = 1'b0;
    bus.m_axi_bresp  = 2'b00;
    bus.m_axi_bid    = '0;
    forever begin
      @(posedge aclk);
      if (b_pend > 0) begin
        b_pend--;
        if (bp_en) repeat ($urandom_range(0, 7)) @(posedge aclk);
        #1;
        bus.m_axi_bresp  = (bresp_plan.size() > 0) ? bresp_plan.pop_front() : 2'b00;
        bus.m_axi_bvalid = 1'b1;
        do @(negedge aclk); while (!bus.m_axi_bready);
        @(posedge aclk); #1;
        bus.m_axi_bvalid = 1'b0;
        bus.m_axi_bresp  = 2'b00;
      end
    end
  end

  task automatic drive_words(input int n, input int badl);
    int cnt;
    for (int i = 0; i < n; i++) begin
      if (bp_en) begin
        bus.s_axis_tvalid = 1'b0;
        repeat ($urandom_range(0, 3)) begin @(posedge aclk); #1; end
      end
      bus.s_axis_tdata  = 32'(stream_base + i);
      bus.s_axis_tlast  = (badl >= 0) ? (i == badl) : (i == n - 1);
      bus.s_axis_tvalid = 1'b1;
      cnt = 0;
      do begin @(negedge aclk); cnt++; end while (!bus.s_axis_tready && cnt < 300);
      if (!bus.s_axis_tready) begin
        fail_now("stream_timeout");
        bus.s_axis_tvalid = 1'b0;
        return;
      end
      @(posedge aclk); #1;
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 30000) begin @(negedge aclk); cyc++; end
    if (!done) fail_now("done_timeout");
  endtask

  task automatic run_xfer(input string nm, input logic [63:0] a, input logic [31:0] len,
                          input int nw, input int badl, input logic exp_err, input int max_cyc);
    int cyc;
    start_addr      = a;
    transfer_length = len;
    start           = 1'b1;
    fork
      drive_words(nw, badl);
      wait_done(cyc);
    join
    chk({nm, "_done"}, 128'(done), 128'(1'b1));
    chk({nm, "_error"}, 128'(error), 128'(exp_err));
    if (max_cyc > 0) chk({nm, "_latency_ok"}, 128'(cyc <= max_cyc), 128'(1'b1));
    chk({nm, "_aw_left"}, 128'(exp_aw.size()), 128'(0));
    chk({nm, "_w_left"}, 128'(exp_w.size()), 128'(0));
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk({nm, "_done_held"}, 128'({done, error}), 128'({1'b1, exp_err}));
    @(posedge aclk); #1;
    start = 1'b0;
    @(posedge aclk); #1;
    @(negedge aclk);
    chk({nm, "_cleared"}, 128'({done, error}), 128'(2'b00));
    @(posedge aclk); #1;
    exp_aw.delete();
    exp_w.delete();
    bresp_plan.delete();
  endtask

  initial begin
    start = 1'b0; start_addr = '0; transfer_length = '0;
    bus.s_axis_tdata = '0; bus.s_axis_tvalid = 1'b0; bus.s_axis_tlast = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("reset_ctl", 128'({done, error, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_wlast,
                           bus.m_axi_bready, bus.s_axis_tready}), 128'(7'b0));
    chk("reset_wdata", bus.m_axi_wdata, 128'(0));
    chk("reset_aw", 128'({bus.m_axi_awaddr, bus.m_axi_awlen, bus.m_axi_awsize,
                          bus.m_axi_awburst, bus.m_axi_awcache, bus.m_axi_wstrb}), 128'(0));
    @(posedge aclk); #1;
    areset = 1'b0;
    @(posedge aclk); #1;

    // a single beat
    stream_base = 0; word_ctr = 0;
    push_burst(64'h1000, 1);
    run_xfer("single", 64'h1000, 32'd16, 4, -1, 1'b0, 0);

    // a 4 KB split: 4 beats up to the page edge, then 12 beats
    stream_base = 32'h100; word_ctr = 32'h100;
    push_burst(64'h0FC0, 4);
    push_burst(64'h1000, 12);
    run_xfer("split4k", 64'h0FC0, 32'd256, 64, -1, 1'b0, 0);

    // two full 256-beat bursts
    stream_base = 32'h10000; word_ctr = 32'h10000;
    push_burst(64'h0, 256);
    push_burst(64'h1000, 256);
    run_xfer("full", 64'h0, 32'd8192, 2048, -1, 1'b0, 0);

    // SLVERR on the first of two bursts; no second AW is expected
    stream_base = 32'h200; word_ctr = 32'h200;
    push_burst(64'h0F80, 8);
    bresp_plan.push_back(2'b10);
    run_xfer("slverr", 64'h0F80, 32'd256, 32, -1, 1'b1, 0);

    // backpressure on every channel plus gaps in the stream
    bp_en = 1'b1;
    stream_base = 32'h3000; word_ctr = 32'h3000;
    push_burst(64'h1F00, 16);
    push_burst(64'h2000, 16);
    run_xfer("backpressure", 64'h1F00, 32'd512, 128, -1, 1'b0, 0);
    bp_en = 1'b0;

    // bad requests: no AW traffic, done with error within 3 cycles
    run_xfer("len_zero", 64'h1000, 32'd0, 0, -1, 1'b1, 3);
    run_xfer("len_20", 64'h1000, 32'd20, 0, -1, 1'b1, 3);
    run_xfer("misaligned", 64'h8, 32'd16, 0, -1, 1'b1, 3);

    // early tlast on word 2 of 4: the data is still written
    stream_base = 32'h400; word_ctr = 32'h400;
    push_burst(64'h3000, 1);
    run_xfer("early_tlast", 64'h3000, 32'd16, 4, 1, 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
